// File: rtl/handshake_sync_arb_pkg.sv
// Shared types and constants for the handshake_sync channel arbiter.
// Imported by the arbiter top level.
package handshake_sync_arb_pkg;

    localparam int unsigned XFER_CNT_W = 16;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StLaunch   = 2'd1,
        StWaitDrop = 2'd2,
        StWaitDone = 2'd3
    } arb_state_e;

endpackage

// File: rtl/handshake_sync_arb_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr_i, wrapping.
// Produces a one-hot grant, its binary index and an any-eligible flag.
module handshake_sync_arb_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    int unsigned     pos;
    logic [ID_W-1:0] pos_idx;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            // Walk offsets from the pointer; the first hit wins.
            pos     = (32'(ptr_i) + i) % N_REQ;
            pos_idx = ID_W'(pos);
            if (!any_o && eligible_i[pos_idx]) begin
                any_o            = 1'b1;
                grant_o[pos_idx] = 1'b1;
                idx_o            = pos_idx;
            end
        end
    end

endmodule

// File: rtl/handshake_sync_arb.sv
// Shares one handshake_sync channel among N_REQ requesters: round-robin grant, held
// {id, payload} word, single launch pulse, then wait for the ready drop/return cycle.
module handshake_sync_arb
    import handshake_sync_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ID_W    = $clog2(N_REQ),
    parameter int unsigned DROP_TO = 8
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    input  logic [N_REQ-1:0]        req_en_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    input  logic [N_REQ-1:0]        req_val_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [ID_W+DATA_W-1:0]  sync_data_o,
    output logic                    sync_val_o,
    input  logic                    sync_ready_i,
    output logic                    done_o,
    output logic                    busy_o,
    output logic [XFER_CNT_W-1:0]   xfer_cnt_o,
    output logic                    timeout_o
);

    localparam int unsigned     TMR_W    = $clog2(DROP_TO);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DROP_TO - 1);
    localparam logic [ID_W-1:0]  IDX_LAST = ID_W'(N_REQ - 1);

    arb_state_e                state_q, state_d;
    logic [ID_W-1:0]           ptr_q, ptr_d;
    logic [ID_W+DATA_W-1:0]    data_q, data_d;
    logic [TMR_W-1:0]          timer_q, timer_d;
    logic                      launch_q, launch_d;
    logic                      done_q, done_d;
    logic [XFER_CNT_W-1:0]     cnt_q, cnt_d;
    logic                      timeout_q, timeout_d;

    logic [N_REQ-1:0]          eligible;
    logic [N_REQ-1:0]          pick_grant;
    logic [ID_W-1:0]           pick_idx;
    logic                      pick_any;
    logic [DATA_W-1:0]         pick_data;
    logic                      grant_fire;

    assign eligible = req_val_i & req_en_i;

    handshake_sync_arb_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .grant_o    (pick_grant),
        .idx_o      (pick_idx),
        .any_o      (pick_any)
    );

    always_comb begin
        pick_data = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (pick_grant[k]) begin
                pick_data = req_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // A grant only happens when the sync is ready to accept a new crossing.
    assign grant_fire = (state_q == StIdle) && pick_any && sync_ready_i;

    // Gated by reset so no requester sees an accept while the block is held in reset.
    assign req_ready_o = (grant_fire && arst_n_i) ? pick_grant : '0;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        data_d    = data_q;
        timer_d   = timer_q;
        launch_d  = 1'b0;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StIdle: begin
                if (grant_fire) begin
                    data_d   = {pick_idx, pick_data};
                    ptr_d    = (pick_idx == IDX_LAST) ? '0 : pick_idx + 1'b1;
                    launch_d = 1'b1;
                    state_d  = StLaunch;
                end
            end
            StLaunch: begin
                timer_d = '0;
                state_d = StWaitDrop;
            end
            StWaitDrop: begin
                if (!sync_ready_i) begin
                    state_d = StWaitDone;
                end else if (timer_q == TMR_LAST) begin
                    // Channel never acknowledged: abandon this word, keep arbitrating.
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (sync_ready_i) begin
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            data_q    <= '0;
            timer_q   <= '0;
            launch_q  <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            data_q    <= data_d;
            timer_q   <= timer_d;
            launch_q  <= launch_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign sync_data_o = data_q;
    assign sync_val_o  = launch_q;
    assign done_o      = done_q;
    assign busy_o      = (state_q != StIdle);
    assign xfer_cnt_o  = cnt_q;
    assign timeout_o   = timeout_q;

endmodule

// File: doc/handshake_sync_arb.md
Name: handshake_sync_arb

Overview:
- Source-domain controller that shares one handshake_sync channel among N requesters.
- Round-robin arbitrates requester valid/ready streams, captures the winner's word plus its ID into a hold register, launches a single transfer into the sync, and waits for the full ready-drop/ready-return cycle before granting again.
- Keeps the data stable for the whole crossing, counts completed transfers and flags a channel that never acknowledges.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_W, 16, payload width per requester.
- ID_W, $clog2(N_REQ), requester-ID width, appended as MSBs of the channel word.
- DROP_TO, 8, max cycles in WAIT_DROP before timeout (>=2).

Ports:
- clk_i  in  1  source-domain clock (same clock as the sync's A side).
- arst_n_i  in  1  asynchronous reset, active-low.
- req_en_i  in  N_REQ  per-requester enable mask; a disabled requester is never granted.
- req_data_i  in  N_REQ*DATA_W  requester payloads; slice k = [k*DATA_W +: DATA_W].
- req_val_i  in  N_REQ  requester valid.
- req_ready_o  out  N_REQ  one-hot accept; a transfer happens when val&ready.
- sync_data_o  out  ID_W+DATA_W  {id, payload} to sync data input; held stable from capture until return to IDLE.
- sync_val_o  out  1  one-cycle launch pulse to sync valid input.
- sync_ready_i  in  1  sync ready output.
- done_o  out  1  one-cycle pulse when a transfer completes.
- busy_o  out  1  high in any state other than IDLE.
- xfer_cnt_o  out  16  completed-transfer count, wraps 0xFFFF->0.
- timeout_o  out  1  sticky error, set on WAIT_DROP timeout.

Behaviour:
- Reset (async assert, sync deassert to clk_i):
  - state=IDLE, rr pointer=0; sync_data_o=0, sync_val_o=0, done_o=0, busy_o=0, xfer_cnt_o=0, timeout_o=0.
  - req_ready_o=0 during reset.
- FSM states: IDLE, LAUNCH, WAIT_DROP, WAIT_DONE.
- IDLE:
  - Eligible requesters are req_val_i & req_en_i.
  - If any are eligible and sync_ready_i=1, pick the first eligible index at or after the pointer (wrapping).
  - req_ready_o[g]=1 combinationally in that cycle only; all other bits stay 0.
  - Capture {g, slice g} into sync_data_o, pointer <= (g+1) mod N_REQ, go to LAUNCH.
  - If sync_ready_i=0 in IDLE: no grant; stay in IDLE.
- LAUNCH (exactly 1 cycle): sync_val_o=1 (registered from state), clear timer, go to WAIT_DROP.
- WAIT_DROP:
  - sync_ready_i=0 -> WAIT_DONE.
  - Otherwise the timer increments; at timer==DROP_TO-1 set timeout_o, drop the transfer (no done_o, no count) and go to IDLE.
- WAIT_DONE: sync_ready_i=1 -> IDLE with done_o=1 for that one cycle and xfer_cnt_o+1; else stay (no timeout here).
- Latency:
  - Grant cycle T, sync_val_o at T+1.
  - With nominal sync, the earliest next grant is the cycle after ready returns.
- Data: sync_data_o changes only on a grant cycle; sync_val_o never asserts while sync_ready_i=0.
- Requesters not granted must hold val/data (AXI-style); dropping val before grant is allowed and just removes eligibility.
- req_en_i changes take effect at the next IDLE evaluation; an in-flight transfer is never aborted by the mask.
- Simultaneous requests: strict round-robin; every enabled, persistently valid requester is granted within N_REQ transfers.
- timeout_o is cleared only by reset; arbitration continues after a timeout.
- Reset mid-transfer: returns to IDLE immediately; a pending crossing in the sync is the system's responsibility (both sides are reset together).

Decomposition:
- Package handshake_sync_arb_pkg: state enum type (IDLE, LAUNCH, WAIT_DROP, WAIT_DONE); XFER_CNT_W=16 constant.
- Sub-module rr_pick: combinational round-robin picker; inputs are eligible mask and pointer, outputs are one-hot grant, index and any-valid.
- The top level holds the FSM, hold register, timer and counters.

Test Plan:
- Single requester 2 sends 0xBEEF with the sync model idle -> req_ready_o=4'b0100 for one cycle, sync_data_o={2'd2,16'hBEEF}, sync_val_o pulse 1 cycle later, done_o after ready returns, xfer_cnt_o=1.
- All 4 requesters valid continuously, pointer=0 -> grant order 0,1,2,3,0; one launch per completed sync cycle; sync_data_o stable between each grant and its done_o.
- req_en_i=4'b1011 with all valid -> grants 0,1,3,0; requester 2 is never granted.
- Stuck sync model (sync_ready_i held 1) -> after DROP_TO=8 cycles in WAIT_DROP, timeout_o=1, no done_o, xfer_cnt_o unchanged; next request is still granted.
- sync_ready_i=0 in IDLE with valid requests -> no req_ready_o and no sync_val_o until ready=1.
- arst_n_i pulled low during WAIT_DONE -> all outputs return to reset values immediately; the next grant after release starts from pointer 0.
